// File: rtl/perf_stage_monitor.sv
// Multi-stage run monitor: per-stage busy span, trailing bubble and active count, read via a registered select.
// Build option: define PERF_MON_ACT_COUNT_EN to implement per-stage active-cycle counters (field 2).
module perf_stage_monitor #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RESET,
  input  logic                  ARM,
  input  logic                  CLEAR,
  input  logic [NUM_STAGES-1:0] ACT,
  input  logic [NUM_STAGES-1:0] END_EVT,
  input  logic [STG_W-1:0]      RD_STAGE,
  input  logic [1:0]            RD_FIELD,
  output logic [CNT_W-1:0]      RD_DATA,
  output logic [STG_W-1:0]      CUR_STAGE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [STG_W-1:0] r_stage;
  logic [CNT_W-1:0] r_elapsed;
  logic [CNT_W-1:0] r_last_act;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [CNT_W-1:0] r_rd_data;
  logic [CNT_W-1:0] r_span   [NUM_STAGES];
  logic [CNT_W-1:0] r_bubble [NUM_STAGES];
`ifdef PERF_MON_ACT_COUNT_EN
  logic [CNT_W-1:0] r_act_cnt;
  logic [CNT_W-1:0] r_acnt   [NUM_STAGES];
  logic [CNT_W-1:0] w_cnt_new;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_sel_acnt;
`endif

  logic             w_act;
  logic             w_end;
  logic [STG_W-1:0] w_next_stage;
  logic             w_act_next;
  logic [CNT_W-1:0] w_last;
  logic             w_elapsed_sat;
  logic [CNT_W-1:0] w_elapsed_inc;
  logic             w_sel_ok;
  logic [CNT_W-1:0] w_sel_span;
  logic [CNT_W-1:0] w_sel_bubble;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_rd_val;

  // Current-stage view of the strobes and saturating working-counter updates
  always_comb begin
    w_act         = ACT[r_stage];
    w_end         = END_EVT[r_stage];
    w_next_stage  = r_stage + STG_W'(1);
    w_act_next    = (r_stage != LAST_STG) && ACT[w_next_stage];
    w_last        = w_act ? r_elapsed : r_last_act;
    w_elapsed_sat = (r_elapsed == CNT_MAX);
    w_elapsed_inc = w_elapsed_sat ? r_elapsed : r_elapsed + CNT_W'(1);
`ifdef PERF_MON_ACT_COUNT_EN
    w_cnt_sat     = w_act && (r_act_cnt == CNT_MAX);
    w_cnt_new     = (w_act && !w_cnt_sat) ? r_act_cnt + CNT_W'(1) : r_act_cnt;
`endif
  end

  // Readback mux; out-of-range stages read zero
  always_comb begin
    w_sel_ok     = (32'(RD_STAGE) < NUM_STAGES);
    w_sel_span   = '0;
    w_sel_bubble = '0;
`ifdef PERF_MON_ACT_COUNT_EN
    w_sel_acnt   = '0;
`endif
    if (w_sel_ok) begin
      w_sel_span   = r_span[RD_STAGE];
      w_sel_bubble = r_bubble[RD_STAGE];
`ifdef PERF_MON_ACT_COUNT_EN
      w_sel_acnt   = r_acnt[RD_STAGE];
`endif
    end
    w_sum    = {1'b0, w_sel_span} + {1'b0, w_sel_bubble};
    w_rd_val = '0;
    case (RD_FIELD)
      2'd0:    w_rd_val = w_sel_span;
      2'd1:    w_rd_val = w_sel_bubble;
`ifdef PERF_MON_ACT_COUNT_EN
      2'd2:    w_rd_val = w_sel_acnt;
`else
      2'd2:    w_rd_val = '0;
`endif
      default: w_rd_val = w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
    endcase
  end

  // Run sequencer; a stage's entry cycle is handled by the transition into it
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RESET) begin
      r_state    <= S_IDLE;
      r_stage    <= '0;
      r_elapsed  <= '0;
      r_last_act <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_data  <= '0;
`ifdef PERF_MON_ACT_COUNT_EN
      r_act_cnt  <= '0;
`endif
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        r_span[i]   <= '0;
        r_bubble[i] <= '0;
`ifdef PERF_MON_ACT_COUNT_EN
        r_acnt[i]   <= '0;
`endif
      end
    end else begin
      r_rd_data <= w_rd_val;
      if (CLEAR) begin
        r_state    <= S_IDLE;
        r_stage    <= '0;
        r_elapsed  <= '0;
        r_last_act <= '0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
        r_ovf      <= 1'b0;
`ifdef PERF_MON_ACT_COUNT_EN
        r_act_cnt  <= '0;
`endif
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
          r_span[i]   <= '0;
          r_bubble[i] <= '0;
`ifdef PERF_MON_ACT_COUNT_EN
          r_acnt[i]   <= '0;
`endif
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ARM) r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (ACT[0]) begin
              r_state    <= S_RUN;
              r_busy     <= 1'b1;
              r_stage    <= '0;
              r_elapsed  <= CNT_W'(1);
              r_last_act <= '0;
`ifdef PERF_MON_ACT_COUNT_EN
              r_act_cnt  <= CNT_W'(1);
`endif
            end
          end
          S_RUN: begin
`ifdef PERF_MON_ACT_COUNT_EN
            if (w_cnt_sat) r_ovf <= 1'b1;
`endif
            if (w_end) begin
              r_span[r_stage]   <= w_last;
              r_bubble[r_stage] <= r_elapsed - w_last;
`ifdef PERF_MON_ACT_COUNT_EN
              r_acnt[r_stage]   <= w_cnt_new;
`endif
              if (r_stage == LAST_STG) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                // END cycle doubles as entry cycle of the next stage
                r_stage    <= w_next_stage;
                r_elapsed  <= CNT_W'(1);
                r_last_act <= '0;
`ifdef PERF_MON_ACT_COUNT_EN
                r_act_cnt  <= w_act_next ? CNT_W'(1) : '0;
`endif
              end
            end else begin
              r_elapsed  <= w_elapsed_inc;
              r_last_act <= w_last;
              if (w_elapsed_sat) r_ovf <= 1'b1;
`ifdef PERF_MON_ACT_COUNT_EN
              r_act_cnt  <= w_cnt_new;
`endif
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifndef PERF_MON_ACT_COUNT_EN
  logic w_unused;
  assign w_unused = w_act_next;
`endif

  assign RD_DATA   = r_rd_data;
  assign CUR_STAGE = r_stage;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign OVF       = r_ovf;

endmodule
